// File: rtl/mem_access_master.sv
// -----------------------------------------------------------------------------
// mem_access_master
//   Single-outstanding initiator for the Memory_System request interface.
//   Takes one read or write at a time from a core-side valid/ready port,
//   drives the memory for exactly one access cycle, waits out the synchronous
//   read latency, then returns read data on a held valid/ready response port.
//
// Parameters
//   DATA_WIDTH    read/write data width
//   ADDR_WIDTH    address width (matches the Memory_System address port)
//   READ_LATENCY  cycles from the access cycle to mem_rdata_i valid (1..4)
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   req_valid_i / req_ready_o  core request handshake (ready = idle)
//   req_we_i, req_addr_i,
//   req_wdata_i                request fields, sampled on acceptance only
//   rsp_valid_o / rsp_ready_i  read response handshake (valid held)
//   rsp_data_o                 read data, held until the next capture
//   mem_addr_o, mem_we_o,
//   mem_wdata_o, mem_rdata_i   Memory_System side
//   rd_cnt_o, wr_cnt_o         saturating accepted-read/write counters
//
// Configuration
//   MEM_ACCESS_PERF_CNT_EN  when defined, rd_cnt_o/wr_cnt_o count accepted
//                           reads/writes; otherwise they are tied to zero.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module mem_access_master #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 64,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic [15:0]           rd_cnt_o,
  output logic [15:0]           wr_cnt_o
);

  generate
    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
      $error("mem_access_master: READ_LATENCY must be in 1..4");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_CAPTURE,
    S_RESP
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic [1:0]            r_wait_cnt;   // remaining WAIT cycles; max READ_LATENCY-1 = 3
  logic                  w_accept;

  assign w_accept = req_valid_i && (r_state == S_IDLE);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic.
  // NOTE: the default assignment first keeps this process free of inferred latches.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_next_state = S_ACCESS;
      S_ACCESS: begin
        if (r_we)                   w_next_state = S_IDLE;
        else if (READ_LATENCY == 1) w_next_state = S_CAPTURE;
        else                        w_next_state = S_WAIT;
      end
      S_WAIT:    if (r_wait_cnt == 2'd1) w_next_state = S_CAPTURE;
      S_CAPTURE: w_next_state = S_RESP;
      S_RESP:    if (rsp_ready_i) w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // State-decoded outputs. Because they decode the asynchronously reset state
  // register, mem_we_o and rsp_valid_o fall the moment rst_n asserts.
  always_comb begin
    req_ready_o = 1'b0;
    mem_we_o    = 1'b0;
    rsp_valid_o = 1'b0;
    case (r_state)
      S_IDLE:   req_ready_o = 1'b1;
      S_ACCESS: mem_we_o    = r_we;
      S_RESP:   rsp_valid_o = 1'b1;
      default:  ;
    endcase
  end

  // Request latch, latency down-counter and read-data capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we        <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rsp_data  <= '0;
      r_wait_cnt  <= '0;
    end else begin
      if (w_accept) begin
        r_we        <= req_we_i;
        r_mem_addr  <= req_addr_i;
        r_mem_wdata <= req_wdata_i;
      end
      // Loaded during ACCESS so WAIT lasts exactly READ_LATENCY-1 cycles.
      if (r_state == S_ACCESS)    r_wait_cnt <= 2'(READ_LATENCY - 1);
      else if (r_state == S_WAIT) r_wait_cnt <= r_wait_cnt - 2'd1;
      if (r_state == S_CAPTURE)   r_rsp_data <= mem_rdata_i;
    end
  end

  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;
  assign rsp_data_o  = r_rsp_data;

`ifdef MEM_ACCESS_PERF_CNT_EN
  logic [15:0] r_rd_cnt;
  logic [15:0] r_wr_cnt;

  // Saturating counters: hold at 16'hFFFF rather than wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else if (w_accept) begin
      if (!req_we_i && r_rd_cnt != 16'hFFFF) r_rd_cnt <= r_rd_cnt + 16'd1;
      if (req_we_i  && r_wr_cnt != 16'hFFFF) r_wr_cnt <= r_wr_cnt + 16'd1;
    end
  end

  assign rd_cnt_o = r_rd_cnt;
  assign wr_cnt_o = r_wr_cnt;
`else
  assign rd_cnt_o = 16'h0;
  assign wr_cnt_o = 16'h0;
`endif

endmodule
